// File: rtl/hpu_clint_resp_if.sv
// LSU <-> CLINT load/store port.
//   master : LSU side; drives load requests and committed stores, receives load responses.
//   slave  : CLINT side; receives requests/stores, drives the 1-cycle-latency response.
// Signals:
//   lsu_clint__rd_en     load request pulse (no backpressure)
//   lsu_clint__raddr     load byte address
//   clint_lsu__rd_vld    response valid, one cycle after rd_en
//   clint_lsu__rd_data   response data (0 when not valid)
//   clint_lsu__rd_err    response error: out of window or unaligned
//   lsu_clint__wr_en     committed word store
//   lsu_clint__waddr     store byte address
//   lsu_clint__wdata     store data
interface hpu_clint_resp_if;
   logic        lsu_clint__rd_en;
   logic [31:0] lsu_clint__raddr;
   logic        clint_lsu__rd_vld;
   logic [31:0] clint_lsu__rd_data;
   logic        clint_lsu__rd_err;
   logic        lsu_clint__wr_en;
   logic [31:0] lsu_clint__waddr;
   logic [31:0] lsu_clint__wdata;

   modport master (
      output lsu_clint__rd_en, lsu_clint__raddr,
      output lsu_clint__wr_en, lsu_clint__waddr, lsu_clint__wdata,
      input  clint_lsu__rd_vld, clint_lsu__rd_data, clint_lsu__rd_err
   );

   modport slave (
      input  lsu_clint__rd_en, lsu_clint__raddr,
      input  lsu_clint__wr_en, lsu_clint__waddr, lsu_clint__wdata,
      output clint_lsu__rd_vld, clint_lsu__rd_data, clint_lsu__rd_err
   );
endinterface

// File: rtl/hpu_clint_resp.sv
// CLINT responder for a single hart: holds msip, mtimecmp and the 64-bit mtime counter,
// answers LSU loads with fixed 1-cycle latency, accepts committed word stores and drives
// the machine software/timer interrupt lines.
// Ports:
//   clk_i               clock
//   rst_i               asynchronous reset, active-high
//   lsu_io              LSU load/store port (slave side)
//   time_stop_i         debug halt: freezes mtime and its prescaler
//   clint_csr__msip_o   software interrupt pending
//   clint_csr__mtip_o   timer interrupt pending (registered)
//   clint_csr__mtime_o  live mtime value
module hpu_clint_resp #(
   parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
   parameter int unsigned TICK_DIV   = 1,
   parameter logic [15:0] MSIP_OFS   = 16'h0000,
   parameter logic [15:0] MTCMP_OFS  = 16'h4000,
   parameter logic [15:0] MTIME_OFS  = 16'hbff8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   hpu_clint_resp_if.slave         lsu_io,
   input  logic                    time_stop_i,
   output logic                    clint_csr__msip_o,
   output logic                    clint_csr__mtip_o,
   output logic [63:0]             clint_csr__mtime_o
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);
   localparam logic [15:0] MtcmpHiOfs = MTCMP_OFS + 16'd4;
   localparam logic [15:0] MtimeHiOfs = MTIME_OFS + 16'd4;

   typedef enum logic [2:0] {
      RegNone, RegMsip, RegCmpLo, RegCmpHi, RegTimeLo, RegTimeHi
   } reg_sel_e;

   function automatic reg_sel_e decode_ofs(input logic [15:0] ofs);
      reg_sel_e sel;
      sel = RegNone;
      if (ofs == MSIP_OFS)        sel = RegMsip;
      else if (ofs == MTCMP_OFS)  sel = RegCmpLo;
      else if (ofs == MtcmpHiOfs) sel = RegCmpHi;
      else if (ofs == MTIME_OFS)  sel = RegTimeLo;
      else if (ofs == MtimeHiOfs) sel = RegTimeHi;
      return sel;
   endfunction

   logic [PW-1:0] presc_q, presc_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtcmp_q, mtcmp_d;
   logic          msip_q, msip_d;
   logic          mtip_q, mtip_d;
   logic          rd_vld_q;
   logic [31:0]   rd_data_q, rd_data_d;
   logic          rd_err_q, rd_err_d;

   // Relative addresses: window membership is "upper half of the offset is zero".
   logic [31:0] rd_rel, wr_rel;
   logic        rd_ok, wr_ok, tick;
   reg_sel_e    rd_sel, wr_sel;

   assign rd_rel = lsu_io.lsu_clint__raddr - CLINT_BASE;
   assign wr_rel = lsu_io.lsu_clint__waddr - CLINT_BASE;
   assign rd_ok  = (rd_rel[31:16] == 16'h0) && (rd_rel[1:0] == 2'b00);
   assign wr_ok  = (wr_rel[31:16] == 16'h0) && (wr_rel[1:0] == 2'b00);
   assign rd_sel = decode_ofs(rd_rel[15:0]);
   assign wr_sel = lsu_io.lsu_clint__wr_en && wr_ok ? decode_ofs(wr_rel[15:0]) : RegNone;
   assign tick   = !time_stop_i && (presc_q == PrescMax);

   // Prescaler keeps counting even when a store overrides the mtime increment.
   always_comb begin
      presc_d = presc_q;
      if (!time_stop_i) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end
   end

   // A store to one half replaces the whole increment: the other half holds (no carry).
   always_comb begin
      mtime_d = mtime_q;
      mtcmp_d = mtcmp_q;
      msip_d  = msip_q;
      if (tick) mtime_d = mtime_q + 64'd1;
      unique case (wr_sel)
         RegMsip:   msip_d  = lsu_io.lsu_clint__wdata[0];
         RegCmpLo:  mtcmp_d = {mtcmp_q[63:32], lsu_io.lsu_clint__wdata};
         RegCmpHi:  mtcmp_d = {lsu_io.lsu_clint__wdata, mtcmp_q[31:0]};
         RegTimeLo: mtime_d = {mtime_q[63:32], lsu_io.lsu_clint__wdata};
         RegTimeHi: mtime_d = {lsu_io.lsu_clint__wdata, mtime_q[31:0]};
         default:   ;
      endcase
   end

   assign mtip_d = (mtime_d >= mtcmp_d);

   // Reads sample current register values, so a same-cycle store is not visible.
   always_comb begin
      rd_data_d = '0;
      rd_err_d  = 1'b0;
      if (lsu_io.lsu_clint__rd_en) begin
         if (!rd_ok) begin
            rd_err_d = 1'b1;
         end else begin
            unique case (rd_sel)
               RegMsip:   rd_data_d = {31'b0, msip_q};
               RegCmpLo:  rd_data_d = mtcmp_q[31:0];
               RegCmpHi:  rd_data_d = mtcmp_q[63:32];
               RegTimeLo: rd_data_d = mtime_q[31:0];
               RegTimeHi: rd_data_d = mtime_q[63:32];
               default:   rd_data_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q   <= '0;
         mtime_q   <= '0;
         mtcmp_q   <= '1;
         msip_q    <= 1'b0;
         mtip_q    <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
         rd_err_q  <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         mtime_q   <= mtime_d;
         mtcmp_q   <= mtcmp_d;
         msip_q    <= msip_d;
         mtip_q    <= mtip_d;
         rd_vld_q  <= lsu_io.lsu_clint__rd_en;
         rd_data_q <= rd_data_d;
         rd_err_q  <= rd_err_d;
      end
   end

   assign lsu_io.clint_lsu__rd_vld  = rd_vld_q;
   assign lsu_io.clint_lsu__rd_data = rd_data_q;
   assign lsu_io.clint_lsu__rd_err  = rd_err_q;
   assign clint_csr__msip_o         = msip_q;
   assign clint_csr__mtip_o         = mtip_q;
   assign clint_csr__mtime_o        = mtime_q;

endmodule

// File: tb/tb_hpu_clint_resp.sv
// Directed bench for hpu_clint_resp with TICK_DIV=4. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_hpu_clint_resp;
   localparam logic [31:0] A_MSIP    = 32'h0200_0000;
   localparam logic [31:0] A_CMP_LO  = 32'h0200_4000;
   localparam logic [31:0] A_CMP_HI  = 32'h0200_4004;
   localparam logic [31:0] A_TIME_LO = 32'h0200_bff8;
   localparam logic [31:0] A_TIME_HI = 32'h0200_bffc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        time_stop = 1'b1;
   logic        msip, mtip;
   logic [63:0] mtime;
   int          checks = 0;
   int          errors = 0;
   bit          ok;

   hpu_clint_resp_if bus ();

   hpu_clint_resp #(
      .TICK_DIV (4)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .lsu_io             (bus.slave),
      .time_stop_i        (time_stop),
      .clint_csr__msip_o  (msip),
      .clint_csr__mtip_o  (mtip),
      .clint_csr__mtime_o (mtime)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at a falling edge.
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      bus.lsu_clint__wr_en = 1'b1;
      bus.lsu_clint__waddr = addr;
      bus.lsu_clint__wdata = data;
      @(negedge clk);
      bus.lsu_clint__wr_en = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                     input logic exp_err);
      bus.lsu_clint__rd_en = 1'b1;
      bus.lsu_clint__raddr = addr;
      @(negedge clk);
      bus.lsu_clint__rd_en = 1'b0;
      chk({tag, ".vld"}, {63'b0, bus.clint_lsu__rd_vld}, 64'd1);
      chk({tag, ".data"}, {32'b0, bus.clint_lsu__rd_data}, {32'b0, exp});
      chk({tag, ".err"}, {63'b0, bus.clint_lsu__rd_err}, {63'b0, exp_err});
      @(negedge clk);
      chk({tag, ".vld_drop"}, {63'b0, bus.clint_lsu__rd_vld}, 64'd0);
      chk({tag, ".data_idle"}, {32'b0, bus.clint_lsu__rd_data}, 64'd0);
   endtask

   task automatic wait_mtime(input logic [63:0] v, output bit found);
      found = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (mtime == v) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      bus.lsu_clint__rd_en = 1'b0;
      bus.lsu_clint__raddr = '0;
      bus.lsu_clint__wr_en = 1'b0;
      bus.lsu_clint__waddr = '0;
      bus.lsu_clint__wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state, time frozen
      chk("rst.vld", {63'b0, bus.clint_lsu__rd_vld}, 64'd0);
      chk("rst.mtip", {63'b0, mtip}, 64'd0);
      chk("rst.msip", {63'b0, msip}, 64'd0);
      chk("rst.mtime", mtime, 64'd0);
      rd("rst_time_lo", A_TIME_LO, 32'h0, 1'b0);
      rd("rst_time_hi", A_TIME_HI, 32'h0, 1'b0);
      rd("rst_cmp_lo", A_CMP_LO, 32'hffff_ffff, 1'b0);
      rd("rst_cmp_hi", A_CMP_HI, 32'hffff_ffff, 1'b0);
      rd("rst_msip", A_MSIP, 32'h0, 1'b0);
      rd("unmapped", 32'h0200_1000, 32'h0, 1'b0);

      // 40 running cycles at TICK_DIV=4 contain exactly 10 ticks
      wr(A_TIME_LO, 32'h0);
      time_stop = 1'b0;
      repeat (40) @(negedge clk);
      time_stop = 1'b1;
      chk("run40", mtime, 64'd10);
      repeat (8) @(negedge clk);
      chk("stop8", mtime, 64'd10);
      rd("run40_lo", A_TIME_LO, 32'd10, 1'b0);

      // Carry lo->hi across two ticks
      wr(A_TIME_LO, 32'hffff_fffe);
      wr(A_TIME_HI, 32'h0);
      chk("wr_mtime", mtime, 64'h0000_0000_ffff_fffe);
      time_stop = 1'b0;
      repeat (8) @(negedge clk);
      time_stop = 1'b1;
      rd("carry_lo", A_TIME_LO, 32'h0, 1'b0);
      rd("carry_hi", A_TIME_HI, 32'h1, 1'b0);

      // Timer interrupt at mtime == mtimecmp == 100
      wr(A_TIME_HI, 32'h0);
      wr(A_TIME_LO, 32'h0);
      wr(A_CMP_LO, 32'd100);
      wr(A_CMP_HI, 32'h0);
      chk("mtip_low", {63'b0, mtip}, 64'd0);
      time_stop = 1'b0;
      wait_mtime(64'd99, ok);
      chk("reach99", {63'b0, ok}, 64'd1);
      chk("mtip_at99", {63'b0, mtip}, 64'd0);
      wait_mtime(64'd100, ok);
      time_stop = 1'b1;
      chk("reach100", {63'b0, ok}, 64'd1);
      chk("mtip_at100", {63'b0, mtip}, 64'd1);
      wr(A_CMP_HI, 32'h1);
      chk("mtip_clr", {63'b0, mtip}, 64'd0);
      rd("cmp_hi", A_CMP_HI, 32'h1, 1'b0);

      // Same-cycle read and write of MSIP returns the old value
      bus.lsu_clint__rd_en = 1'b1;
      bus.lsu_clint__raddr = A_MSIP;
      bus.lsu_clint__wr_en = 1'b1;
      bus.lsu_clint__waddr = A_MSIP;
      bus.lsu_clint__wdata = 32'h1;
      @(negedge clk);
      bus.lsu_clint__rd_en = 1'b0;
      bus.lsu_clint__wr_en = 1'b0;
      chk("rbw.vld", {63'b0, bus.clint_lsu__rd_vld}, 64'd1);
      chk("rbw.data", {32'b0, bus.clint_lsu__rd_data}, 64'd0);
      chk("rbw.msip", {63'b0, msip}, 64'd1);
      rd("msip_set", A_MSIP, 32'h1, 1'b0);

      // Out-of-window and unaligned accesses
      rd("oow", 32'h0201_0000, 32'h0, 1'b1);
      rd("unal", 32'h0200_0002, 32'h0, 1'b1);
      wr(32'h0201_0000, 32'h0);
      wr(32'h0200_0002, 32'h0);
      chk("bad_wr_msip", {63'b0, msip}, 64'd1);
      wr(32'h0201_bff8, 32'h0);
      wr(32'h0200_bffa, 32'h0);
      chk("bad_wr_mtime", mtime, 64'd100);

      // Reset while a response is pending
      bus.lsu_clint__rd_en = 1'b1;
      bus.lsu_clint__raddr = A_MSIP;
      @(posedge clk);
      #1;
      chk("pend.vld", {63'b0, bus.clint_lsu__rd_vld}, 64'd1);
      rst = 1'b1;
      bus.lsu_clint__rd_en = 1'b0;
      #1;
      chk("rstmid.vld", {63'b0, bus.clint_lsu__rd_vld}, 64'd0);
      chk("rstmid.data", {32'b0, bus.clint_lsu__rd_data}, 64'd0);
      chk("rstmid.msip", {63'b0, msip}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      rd("post_rst_cmp_hi", A_CMP_HI, 32'hffff_ffff, 1'b0);
      rd("post_rst_time_lo", A_TIME_LO, 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
